pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 16: instruction/payload width.
REQ-002 Parameter PC_W, default 16: PC field width.
REQ-003 Parameter NOP_VAL, default all-zero DATA_W: payload presented when the stage holds a bubble.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  discard all held entries.
REQ-007 in_valid  input  1  upstream offers an entry.
REQ-008 in_ready  output  1  stage accepts an entry this cycle.
REQ-009 in_pc  input  PC_W  upstream PC.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 out_valid  output  1  out_pc/out_data hold a real entry.
REQ-012 out_ready  input  1  downstream consumes this cycle (low = stall).
REQ-013 out_pc  output  PC_W  held PC.
REQ-014 out_data  output  DATA_W  held payload, NOP_VAL when out_valid low.

Function
REQ-015 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; no other event moves data.
REQ-016 States: EMPTY (no entry), ONE (main slot valid), TWO (main and skid slots valid); in_ready SHALL be high in EMPTY and ONE, low in TWO, and SHALL be a register output.
REQ-017 EMPTY: transfer in -> load main, go ONE; latency in-to-out one cycle.
REQ-018 ONE: in & out together -> main reloads, stay ONE; out only -> EMPTY; in only -> load skid, go TWO.
REQ-019 TWO: out -> skid moves to main, go ONE; no out -> hold both.
REQ-020 Ordering SHALL be strictly FIFO; no entry lost or duplicated under any in_valid/out_ready pattern.
REQ-021 Sustained in_valid=1, out_ready=1 SHALL give one transfer per cycle.
REQ-022 flush SHALL take priority over all other events: next cycle state EMPTY, out_valid 0, out_data NOP_VAL, out_pc 0; simultaneous transfer in SHALL be discarded.
REQ-023 Whenever out_valid is 0, out_data SHALL equal NOP_VAL and out_pc SHALL equal 0.
REQ-024 in_data/in_pc SHALL be ignored when in_valid is 0.

Reset
REQ-025 While rst low: state EMPTY, out_valid 0, in_ready 1, out_data NOP_VAL, out_pc 0, skid slot invalid.
REQ-026 Assertion SHALL take effect without a clock edge; reset mid-TWO discards both entries.
REQ-027 First transfer in permitted on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN defined: two-slot skid behaviour per REQ-016..REQ-019.
REQ-029 Macro undefined: skid slot and TWO state removed; in_ready = ~out_valid | out_ready (combinational); all other requirements unchanged.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and the default NOP constant.
REQ-031 Sub-module pipe_slot (valid bit + PC + payload register with load and clear, NOP on clear) SHALL be instantiated for main and skid slots.

Verification
REQ-032 Reset then in_valid=1, in_pc=0x0010, in_data=0xA5A5, out_ready=1 -> next cycle out_valid=1, out_pc=0x0010, out_data=0xA5A5.
REQ-033 Stream 0x0001..0x0008 with out_ready=1 -> eight consecutive outputs 0x0001..0x0008, in_ready constant 1.
REQ-034 out_ready=0 while sending 0x0011, 0x0022, 0x0033 -> 0x0011 in main, 0x0022 in skid, in_ready 0, 0x0033 held upstream; out_ready=1 -> outputs 0x0011, 0x0022, 0x0033 in order.
REQ-035 State TWO, flush=1 with in_valid=1 in_data=0x00FF -> next cycle out_valid=0, out_data=0x0000, in_ready=1, 0x00FF never appears.
REQ-036 rst low asynchronously between edges in TWO -> outputs reset immediately; after release, first output is the next accepted entry.
REQ-037 PIPE_STAGE_SKID_EN undefined, out_ready=0 with out_valid=1 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy states and
// the default bubble pattern used when a slot holds no entry.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    // Replicated across the payload width to form the default NOP word.
    localparam logic NOP_BIT = 1'b0;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// One entry holding register: valid bit, PC and payload with load and clear.
// A cleared slot presents PC zero and the NOP payload.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 16,
    parameter int                PC_W    = 16,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{NOP_BIT}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [PC_W-1:0]   ld_pc,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next slot contents: clear wins over load so a bubble never carries stale data.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            pc_d    = {PC_W{1'b0}};
            data_d  = NOP_VAL;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = ld_pc;
            data_d  = ld_data;
        end else begin
            valid_d = valid_q;
            pc_d    = pc_q;
            data_d  = data_q;
        end
    end

    // Slot register with asynchronous reset to the bubble pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= {PC_W{1'b0}};
            data_q  <= NOP_VAL;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign data  = data_q;

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register. Define PIPE_STAGE_SKID_EN for the
// two-slot skid version with registered in_ready; otherwise single slot.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 16,
    parameter int                PC_W    = 16,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{NOP_BIT}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data
);

    stage_state_e      state_q, state_d;
    logic              xfer_in_s, xfer_out_s;
    logic              main_load_s, main_clear_s;
    logic [PC_W-1:0]   main_ld_pc_s;
    logic [DATA_W-1:0] main_ld_data_s;
    logic              main_valid_s;
    logic [PC_W-1:0]   main_pc_s;
    logic [DATA_W-1:0] main_data_s;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_load_s, skid_clear_s, main_from_skid_s;
    logic              skid_valid_s;
    logic [PC_W-1:0]   skid_pc_s;
    logic [DATA_W-1:0] skid_data_s;
    logic              in_ready_q, in_ready_d;

    assign in_ready       = in_ready_q;
    assign main_ld_pc_s   = main_from_skid_s ? skid_pc_s : in_pc;
    assign main_ld_data_s = main_from_skid_s ? skid_data_s : in_data;
`else
    // Without a skid slot the stage can only take a new entry when the held one leaves.
    assign in_ready       = ~main_valid_s | out_ready;
    assign main_ld_pc_s   = in_pc;
    assign main_ld_data_s = in_data;
`endif

    assign xfer_in_s  = in_valid & in_ready;
    assign xfer_out_s = main_valid_s & out_ready;

    // Occupancy next-state and slot control; flush overrides every transfer.
    always_comb begin
        state_d      = state_q;
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        main_from_skid_s = 1'b0;
`endif
        if (flush) begin
            state_d      = EMPTY;
            main_clear_s = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            skid_clear_s = 1'b1;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (xfer_in_s) begin
                        main_load_s = 1'b1;
                        state_d     = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (xfer_in_s && xfer_out_s) begin
                        main_load_s = 1'b1;
                        state_d     = ONE;
                    end else if (xfer_out_s) begin
                        main_clear_s = 1'b1;
                        state_d      = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (xfer_in_s) begin
                        skid_load_s = 1'b1;
                        state_d     = TWO;
`endif
                    end else begin
                        state_d = ONE;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                TWO: begin
                    // Skid contents advance into main; an empty skid here is recovered to EMPTY.
                    if (xfer_out_s) begin
                        main_load_s      = skid_valid_s;
                        main_clear_s     = ~skid_valid_s;
                        main_from_skid_s = 1'b1;
                        skid_clear_s     = 1'b1;
                        state_d          = skid_valid_s ? ONE : EMPTY;
                    end else begin
                        state_d = TWO;
                    end
                end
`endif
                default: begin
                    state_d      = EMPTY;
                    main_clear_s = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    skid_clear_s = 1'b1;
`endif
                end
            endcase
        end
`ifdef PIPE_STAGE_SKID_EN
        in_ready_d = (state_d != TWO);
`endif
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Registered in_ready, precomputed from the next occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    pipe_slot #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .NOP_VAL (NOP_VAL)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load_s),
        .clear   (skid_clear_s),
        .ld_pc   (in_pc),
        .ld_data (in_data),
        .valid   (skid_valid_s),
        .pc      (skid_pc_s),
        .data    (skid_data_s)
    );
`endif

    pipe_slot #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .NOP_VAL (NOP_VAL)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load_s),
        .clear   (main_clear_s),
        .ld_pc   (main_ld_pc_s),
        .ld_data (main_ld_data_s),
        .valid   (main_valid_s),
        .pc      (main_pc_s),
        .data    (main_data_s)
    );

    assign out_valid = main_valid_s;
    assign out_pc    = main_pc_s;
    assign out_data  = main_data_s;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; skid-only scenarios follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pc;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (16),
        .PC_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] d);
        in_valid = v;
        in_pc    = pc;
        in_data  = d;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_data"}, {16'd0, out_data}, 32'h0000_0000);
        chk({tag, "_pc"}, {16'd0, out_pc}, 32'h0000_0000);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] pc, input logic [15:0] d);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
        chk({tag, "_pc"}, {16'd0, out_pc}, {16'd0, pc});
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 16'hDEAD, 16'hBEEF);
        #3;
        chk_bubble("rst_async");
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        tick();
        rst = 1'b1;

        // First accepted entry appears one cycle later.
        out_ready = 1'b1;
        drive(1'b1, 16'h0010, 16'hA5A5);
        #1;
        chk("first_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_out("first", 16'h0010, 16'hA5A5);
        drive(1'b0, 16'h1234, 16'h5678);
        tick();
        chk_bubble("drain");

        // Back-to-back stream at full rate.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(32'h0100 + i), 16'(i));
            #1;
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk_out("stream", 16'(32'h0100 + i), 16'(i));
        end
        drive(1'b0, 16'hDEAD, 16'hBEEF);
        tick();
        chk_bubble("stream_end");

        // Downstream stall.
        out_ready = 1'b0;
        drive(1'b1, 16'h0211, 16'h0011);
        tick();
        chk_out("stall_a", 16'h0211, 16'h0011);
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 16'h0222, 16'h0022);
        #1;
        chk("stall_one_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("stall_two_ready", {31'd0, in_ready}, 32'd0);
        chk_out("stall_hold", 16'h0211, 16'h0011);
        drive(1'b1, 16'h0233, 16'h0033);
        tick();
        chk("stall_still_full", {31'd0, in_ready}, 32'd0);
        chk_out("stall_hold2", 16'h0211, 16'h0011);
        out_ready = 1'b1;
        tick();
        chk_out("stall_b", 16'h0222, 16'h0022);
        chk("stall_reopen", {31'd0, in_ready}, 32'd1);
        tick();
        chk_out("stall_c", 16'h0233, 16'h0033);
`else
        #1;
        chk("comb_ready_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("comb_ready_high", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        drive(1'b1, 16'h0222, 16'h0022);
        #1;
        chk("comb_ready_low2", {31'd0, in_ready}, 32'd0);
        tick();
        chk_out("stall_hold", 16'h0211, 16'h0011);
        out_ready = 1'b1;
        tick();
        chk_out("stall_b", 16'h0222, 16'h0022);
`endif
        drive(1'b0, 16'hDEAD, 16'hBEEF);
        tick();
        chk_bubble("stall_end");

        // Flush while one entry is held and a new one is being accepted.
        out_ready = 1'b1;
        drive(1'b1, 16'h0300, 16'h0077);
        tick();
        chk_out("flush_pre", 16'h0300, 16'h0077);
        drive(1'b1, 16'h03FF, 16'h00FF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_bubble("flush_one");
        chk("flush_one_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 16'hDEAD, 16'hBEEF);
        tick();
        chk_bubble("flush_one_after");

`ifdef PIPE_STAGE_SKID_EN
        // Flush with both slots full.
        out_ready = 1'b0;
        drive(1'b1, 16'h0301, 16'h00A1);
        tick();
        drive(1'b1, 16'h0302, 16'h00A2);
        tick();
        chk("flush_two_full", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 16'h03FF, 16'h00FF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_bubble("flush_two");
        chk("flush_two_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 16'hDEAD, 16'hBEEF);
        out_ready = 1'b1;
        tick();
        chk_bubble("flush_two_after");
`endif

        // Asynchronous reset between edges with entries held.
        out_ready = 1'b0;
        drive(1'b1, 16'h04B1, 16'h00B1);
        tick();
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 16'h04B2, 16'h00B2);
        tick();
        chk("rst_mid_full", {31'd0, in_ready}, 32'd0);
`endif
        chk_out("rst_mid_pre", 16'h04B1, 16'h00B1);
        drive(1'b0, 16'hDEAD, 16'hBEEF);
        #3;
        rst = 1'b0;
        #1;
        chk_bubble("rst_mid");
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'h04C3, 16'h00C3);
        tick();
        chk_out("rst_after", 16'h04C3, 16'h00C3);
        drive(1'b0, 16'hDEAD, 16'hBEEF);
        tick();
        chk_bubble("rst_after_end");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_reg
